// File: rtl/controle_divisor_4bits.sv
// Purpose: restoring-division sequencer for unsigned A/B, driving one shared external 4-bit subtractor.
// Latency: done is high in the cycle after the 4th iteration edge (1 start + 4 iterations), or right after the start edge on divide-by-zero.
// Backpressure: none; start is sampled only while idle, and is ignored while busy or done (a held start restarts every 6 cycles).
module controle_divisor_4bits #(
    parameter int N_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sub_a,
    output logic [N_BITS-1:0] sub_b,
    input  logic [N_BITS-1:0] sub_s,
    input  logic              sub_borrow_out,
    output logic [N_BITS-1:0] quociente,
    output logic [N_BITS-1:0] resto,
    output logic              busy,
    output logic              done,
    output logic              erro_div0
);

    // Only N_BITS = 4 matches the external subtractor width.
    localparam int CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   r_q, r_d;       // partial remainder
    logic [N_BITS-1:0]   q_q, q_d;       // dividend shifting out, quotient bits shifting in
    logic [N_BITS-1:0]   d_q, d_d;       // latched divisor
    logic [CNT_W-1:0]    cnt_q, cnt_d;   // iteration index
    logic [N_BITS-1:0]   quo_q, quo_d;
    logic [N_BITS-1:0]   rest_q, rest_d;
    logic                err_q, err_d;

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [N_BITS-1:0]   shifted;
    logic                qbit;

    assign shifted = {r_q[N_BITS-2:0], q_q[N_BITS-1]};
    assign qbit    = sub_borrow_out;

    assign sub_a     = shifted;
    assign sub_b     = d_q;
    assign quociente = quo_q;
    assign resto     = rest_q;
    assign erro_div0 = err_q;
    assign busy      = (state_q == CALCULA);
    assign done      = (state_q == FIM);

    // State and datapath registers; reset aborts any running division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCIOSO;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rest_q  <= rest_d;
            err_q   <= err_d;
        end
    end

    // Next-state and register updates: accept, iterate one trial subtraction per cycle, publish.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rest_d  = rest_q;
        err_d   = err_q;

        case (state_q)
            OCIOSO: begin
                if (start) begin
                    if (b != '0) begin
                        r_d     = '0;
                        q_d     = a;
                        d_d     = b;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CALCULA;
                    end else begin
                        // Divide-by-zero: saturate quotient, pass dividend through as remainder.
                        quo_d   = '1;
                        rest_d  = a;
                        err_d   = 1'b1;
                        state_d = FIM;
                    end
                end
            end

            CALCULA: begin
                // Restore (keep the shifted value) when the trial subtraction would underflow.
                r_d   = qbit ? sub_s : shifted;
                q_d   = {q_q[N_BITS-2:0], qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quo_d   = {q_q[N_BITS-2:0], qbit};
                    rest_d  = qbit ? sub_s : shifted;
                    state_d = FIM;
                end
            end

            FIM: begin
                state_d = OCIOSO;
            end

            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_divisor_4bits.sv
module tb_controle_divisor_4bits;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic [3:0] sub_a, sub_b, sub_s;
    logic       sub_borrow_out;
    logic [3:0] quociente, resto;
    logic       busy, done, erro_div0;

    always #5 clk = ~clk;

    // External subtractor: pure combinational difference, cout = 1 when no borrow.
    assign sub_s          = sub_a - sub_b;
    assign sub_borrow_out = (sub_a >= sub_b);

    controle_divisor_4bits #(.N_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .sub_a          (sub_a),
        .sub_b          (sub_b),
        .sub_s          (sub_s),
        .sub_borrow_out (sub_borrow_out),
        .quociente      (quociente),
        .resto          (resto),
        .busy           (busy),
        .done           (done),
        .erro_div0      (erro_div0)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..4 iterating, 5 = done cycle.
    // Results come from plain integer / and %.
    int m_phase = 0;
    int m_q = 0, m_r = 0, m_e = 0;
    int ma = 0, mb = 1, pq = 0, pr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_q = 0; m_r = 0; m_e = 0;
        end else begin
            if (m_phase == 0) begin
                if (start === 1'b1) begin
                    if (b == 4'd0) begin
                        m_q = 15; m_r = int'(a); m_e = 1; m_phase = 5;
                    end else begin
                        ma = int'(a); mb = int'(b);
                        pq = ma / mb; pr = ma % mb;
                        m_e = 0; m_phase = 1;
                    end
                end
            end else if (m_phase < 4) begin
                m_phase++;
            end else if (m_phase == 4) begin
                m_q = pq; m_r = pr; m_phase = 5;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_phase >= 1 && m_phase <= 4));
        chk("done", int'(done), int'(m_phase == 5));
        chk("quociente", int'(quociente), m_q);
        chk("resto", int'(resto), m_r);
        chk("erro_div0", int'(erro_div0), m_e);
        if (m_phase >= 1 && m_phase <= 4) begin
            // Iteration k sees 2*(top (k-1) dividend bits mod B) + next dividend bit.
            chk("sub_a", int'(sub_a),
                2 * ((ma >> (5 - m_phase)) % mb) + ((ma >> (4 - m_phase)) & 1));
            chk("sub_b", int'(sub_b), mb);
        end
    end

    task automatic start_op(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
    endtask

    // Returns the number of extra negedges waited before done was seen (-1 on timeout).
    task automatic wait_done(input string nm, output int cyc);
        cyc = -1;
        if (done === 1'b1) begin
            cyc = 0;
        end else begin
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    cyc = i;
                    break;
                end
            end
        end
        if (cyc < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_div(input string nm, input logic [3:0] av, input logic [3:0] bv,
                           input int exp_lat, input int exp_q, input int exp_r, input int exp_e);
        int lat;
        start_op(av, bv);
        wait_done(nm, lat);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_q"}, int'(quociente), exp_q);
        chk({nm, "_r"}, int'(resto), exp_r);
        chk({nm, "_err"}, int'(erro_div0), exp_e);
    endtask

    int perm[256];

    initial begin
        int lat, d0, d1, d2, nd, tmp, j;
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_q", int'(quociente), 0);
        chk("reset_r", int'(resto), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(erro_div0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed divisions with hand-computed results.
        run_div("d13_4", 4'd13, 4'd4, 4, 3, 1, 0);
        run_div("d7_9", 4'd7, 4'd9, 4, 0, 7, 0);
        run_div("d15_1", 4'd15, 4'd1, 4, 15, 0, 0);
        run_div("d5_0", 4'd5, 4'd0, 0, 15, 5, 1);
        run_div("d6_3", 4'd6, 4'd3, 4, 2, 0, 0);

        // Start pulse during busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd15;
        @(negedge clk);
        start = 1'b0;
        wait_done("d9_2", lat);
        chk("d9_2_latency", lat, 2);
        chk("d9_2_q", int'(quociente), 4);
        chk("d9_2_r", int'(resto), 1);

        // Held start: one operation every 6 cycles.
        @(negedge clk);
        start = 1'b1; a = 4'd11; b = 4'd2;
        d0 = -1; d1 = -1; d2 = -1; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (nd == 0) d0 = i; else if (nd == 1) d1 = i; else if (nd == 2) d2 = i;
                nd++;
            end
        end
        start = 1'b0;
        chk("held_gap1", d1 - d0, 6);
        chk("held_gap2", d2 - d1, 6);
        chk("held_q", int'(quociente), 5);
        chk("held_r", int'(resto), 1);
        repeat (8) @(negedge clk);

        // Reset during the 2nd CALCULA cycle aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; a = 4'd14; b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(quociente), 0);
        chk("abort_r", int'(resto), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_div("d14_3", 4'd14, 4'd3, 4, 4, 2, 0);

        // Exhaustive sweep in random order with random idle gaps; model checks every cycle.
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_op(4'(perm[i] >> 4), 4'(perm[i] & 15));
            wait_done("sweep", lat);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
